// File: rtl/silicon_art_uart_tx.sv
// silicon_art_uart_tx
//   Serializes the fixed 16-byte banner "HELLO SILICON!\r\n" as an 8N1 UART
//   stream. A rising edge on start launches one message. If loop is high when
//   the last stop bit ends, the message restarts with no idle gap.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   ena       in   enable; when low, every register holds its value
//   start     in   asynchronous trigger, rising edge launches a message
//   loop      in   sampled at the end of byte 15 to restart the message
//   tx        out  serial data, idle high
//   busy      out  high while a message is being sent
//   done      out  one-cycle pulse after the final stop bit
//   char_idx  out  index of the byte currently on the line (0..15)
module silicon_art_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic       loop,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [3:0] char_idx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [3:0]      idx_q, idx_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            s1_q, s2_q, s3_q;
    logic            trig;
    logic            bit_end;

    function automatic logic [7:0] rom(input logic [3:0] a);
        case (a)
            4'h0: return 8'h48;
            4'h1: return 8'h45;
            4'h2: return 8'h4C;
            4'h3: return 8'h4C;
            4'h4: return 8'h4F;
            4'h5: return 8'h20;
            4'h6: return 8'h53;
            4'h7: return 8'h49;
            4'h8: return 8'h4C;
            4'h9: return 8'h49;
            4'hA: return 8'h43;
            4'hB: return 8'h4F;
            4'hC: return 8'h4E;
            4'hD: return 8'h21;
            4'hE: return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    // s2 is the synchronized level, s3 its previous value: one-cycle edge pulse.
    assign trig    = s2_q & ~s3_q;
    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = START;
                    idx_d   = 4'd0;
                    baud_d  = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    shift_d = rom(idx_q);
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (idx_q != 4'd15) begin
                        idx_d   = idx_q + 4'd1;
                        state_d = START;
                    end else begin
                        done_d  = 1'b1;
                        idx_d   = 4'd0;
                        state_d = loop ? START : IDLE;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is registered from the next state so tx is glitch-free.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            idx_q   <= 4'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            s1_q    <= start;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign char_idx = idx_q;

endmodule
